// File: rtl/inst_queue_if.sv
// rtl/inst_queue_if.sv - packet type and fetch/decode handshake bundle for inst_queue
// A zero packet has inst.i_valid = 0 and reads as a decode bubble.
package inst_queue_pkg;
   typedef struct packed {
      logic        i_valid;
      logic [31:0] i_inst;
   } inst_t;

   typedef struct packed {
      inst_t       inst;
      logic [5:0]  i_order;
      logic [31:0] i_pc;
      logic [31:0] i_pc_next;
      logic        br_pred;
      logic [7:0]  ghr;
   } iq_entry;
endpackage

interface inst_queue_if #(parameter int DEPTH = 16);
   import inst_queue_pkg::*;

   logic                     flush;
   logic                     enq;
   iq_entry                  enq_data;
   logic                     full;
   logic                     deq;
   iq_entry                  deq_data;
   logic                     empty;
   logic [$clog2(DEPTH):0]   count;

   modport master (
      output flush, enq, enq_data, deq,
      input  full, deq_data, empty, count
   );

   modport slave (
      input  flush, enq, enq_data, deq,
      output full, deq_data, empty, count
   );
endinterface

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - circular fetch-to-decode instruction FIFO with single-cycle flush
// Optional same-cycle empty-queue bypass enabled by defining INST_QUEUE_BYPASS_EN.
module inst_queue #(
   parameter int DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   inst_queue_if.slave   q
);
   import inst_queue_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   iq_entry        mem [DEPTH];
   logic [AW-1:0]  head;
   logic [AW-1:0]  tail;
   logic [CW-1:0]  cnt;

   logic full;
   logic empty;
   logic enq_ok;
   logic deq_ok;
   logic bypass;
   logic consume_direct;
   logic wr_en;

   assign full  = (cnt == CW'(DEPTH));
   assign empty = (cnt == '0);

   assign q.full  = full;
   assign q.empty = empty;
   assign q.count = cnt;

`ifdef INST_QUEUE_BYPASS_EN
   assign bypass = empty && q.enq && !q.flush;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed packet taken by decode in the same cycle never touches storage.
   assign consume_direct = bypass && q.deq;
   assign enq_ok         = q.enq && !full;
   assign deq_ok         = q.deq && !empty;
   assign wr_en          = enq_ok && !consume_direct;

   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else if (q.flush) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (wr_en) begin
            tail <= tail + AW'(1);
         end
         if (deq_ok) begin
            head <= head + AW'(1);
         end
         case ({wr_en, deq_ok})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is deliberately not cleared by reset or flush; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (!rst && !q.flush && wr_en) begin
         mem[tail] <= q.enq_data;
      end
   end

   always_comb begin
      q.deq_data = '0;
      if (bypass) begin
         q.deq_data = q.enq_data;
      end else if (!empty) begin
         q.deq_data = mem[head];
      end
   end
endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - scoreboard bench for inst_queue against a queue-based reference model
// Covers the directed scenarios plus a randomized traffic phase.
module tb_inst_queue;
   import inst_queue_pkg::*;

   localparam int DEPTH = 16;

   typedef struct {
      iq_entry    data;
      int         cnt;
   } obs_t;

   logic clk = 1'b0;
   logic rst;

   inst_queue_if #(.DEPTH(DEPTH)) q ();

   inst_queue #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .q   (q)
   );

   always #5 clk = ~clk;

   iq_entry model [$];
   obs_t    obs [$];
   int      checks   = 0;
   int      failures = 0;
   logic [5:0] ord = '0;

   function automatic iq_entry mk(input logic [31:0] pc, input logic [5:0] o);
      iq_entry e;
      e.inst.i_valid = 1'b1;
      e.inst.i_inst  = $urandom;
      e.i_order      = o;
      e.i_pc         = pc;
      e.i_pc_next    = pc + 32'd4;
      e.br_pred      = 1'($urandom_range(0, 1));
      e.ghr          = 8'($urandom);
      return e;
   endfunction

   // Expected visible outputs come from the model state before this cycle's edge.
   task automatic cycle(input logic r, input logic f, input logic e,
                        input iq_entry d, input logic dq);
      obs_t o;
      bit   taken;
      rst        = r;
      q.flush    = f;
      q.enq      = e;
      q.enq_data = d;
      q.deq      = dq;
      o.cnt  = model.size();
      o.data = (model.size() > 0) ? model[0] : '0;
      taken  = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
      if (model.size() == 0 && e && !f) begin
         o.data = d;
         taken  = dq;
      end
`endif
      obs.push_back(o);
      if (r || f) begin
         model.delete();
      end else begin
         int pre = model.size();
         if (dq && pre > 0) void'(model.pop_front());
         if (e && pre < DEPTH && !taken) model.push_back(d);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_pc(input logic [31:0] pc, input logic dq);
      cycle(1'b0, 1'b0, 1'b1, mk(pc, ord), dq);
      ord = ord + 6'd1;
   endtask

   task automatic idle(input int n, input logic dq);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, dq);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
   endtask

   always @(negedge clk) begin
      if (obs.size() > 0) begin
         obs_t o;
         o = obs.pop_front();
         checks++;
         if (q.deq_data !== o.data) begin
            failures++;
            $display("FAIL deq_data got=%h exp=%h", q.deq_data, o.data);
         end
         checks++;
         if (int'(q.count) != o.cnt) begin
            failures++;
            $display("FAIL count got=%0d exp=%0d", q.count, o.cnt);
         end
         checks++;
         if (q.empty !== (o.cnt == 0)) begin
            failures++;
            $display("FAIL empty got=%b exp=%b", q.empty, (o.cnt == 0));
         end
         checks++;
         if (q.full !== (o.cnt == DEPTH)) begin
            failures++;
            $display("FAIL full got=%b exp=%b", q.full, (o.cnt == DEPTH));
         end
      end
   end

   initial begin
      rst        = 1'b1;
      q.flush    = 1'b0;
      q.enq      = 1'b0;
      q.enq_data = '0;
      q.deq      = 1'b0;
      @(posedge clk);
      #1;
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
      idle(3, 1'b0);

      // Fill to full, then a dropped enqueue alongside a dequeue.
      for (int i = 0; i < DEPTH; i++) push_pc(32'h1000 + 32'(4 * i), 1'b0);
      push_pc(32'h1040, 1'b1);
      idle(1, 1'b0);
      drain();

      // Steady-state enq+deq across pointer wrap.
      for (int i = 0; i < 10; i++) push_pc(32'h4000 + 32'(4 * i), 1'b0);
      for (int i = 0; i < 40; i++) push_pc(32'h5000 + 32'(4 * i), 1'b1);
      drain();

      // Flush with concurrent enq and deq, then refill from slot 0.
      for (int i = 0; i < 5; i++) push_pc(32'h6000 + 32'(4 * i), 1'b0);
      cycle(1'b0, 1'b1, 1'b1, mk(32'h6100, ord), 1'b1);
      push_pc(32'h2000, 1'b0);
      idle(1, 1'b0);
      drain();

      // Enqueue with deq on an empty queue.
      push_pc(32'h3000, 1'b1);
      idle(1, 1'b0);
      drain();

      // Dequeue on empty must not underflow.
      idle(4, 1'b1);
      push_pc(32'h3100, 1'b0);
      idle(1, 1'b0);
      drain();

      // Randomized traffic including occasional flush and reset.
      for (int i = 0; i < 600; i++) begin
         logic r, f, e, dq;
         r  = ($urandom_range(0, 63) == 0);
         f  = ($urandom_range(0, 19) == 0);
         e  = ($urandom_range(0, 99) < 60);
         dq = ($urandom_range(0, 99) < 45);
         cycle(r, f, e, mk(32'($urandom) & 32'hFFFF_FFFC, ord), dq);
         ord = ord + 6'd1;
      end
      drain();

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
